// File: rtl/spike_encoder.sv
// Rate-coded spike encoder: turns a vector of pixel intensities into per-channel spike trains.
// Build option SPIKE_ENCODER_DET_EN swaps the per-channel LFSRs for deterministic phase accumulators.
module spike_encoder #(
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned PIXEL_WIDTH   = 8,
    parameter int unsigned NUM_TIMESTEPS = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  load_valid,
    output logic                                  load_ready,
    input  logic [NUM_CHANNELS*PIXEL_WIDTH-1:0]   load_data,
    input  logic                                  start,
    input  logic                                  clear,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  step_valid,
    output logic [$clog2(NUM_TIMESTEPS)-1:0]      timestep,
    output logic [NUM_CHANNELS-1:0]               spike_out
);

    localparam int unsigned TS_W = $clog2(NUM_TIMESTEPS);
    localparam int unsigned DW   = NUM_CHANNELS * PIXEL_WIDTH;
    localparam logic [TS_W-1:0] LAST_TS = TS_W'(NUM_TIMESTEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [DW-1:0]           intensity, intensity_eff;
    logic [TS_W-1:0]         ts_nxt;
    logic [NUM_CHANNELS-1:0] spike_nxt, spike_raw;
    logic                    step_valid_nxt, busy_nxt, done_nxt, load_ready_nxt;
    logic                    load_fire, start_fire, step_fire;

    // A load coinciding with start is forwarded so the run sees the new intensities.
    assign load_fire     = load_valid && load_ready;
    assign intensity_eff = load_fire ? load_data : intensity;
    assign start_fire    = (state == S_IDLE) && start && !clear;
    assign step_fire     = (state == S_RUN) && !clear && (timestep != LAST_TS);

    // Per-channel random/phase source and spike decision for the step being issued.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [PIXEL_WIDTH-1:0] inten;
        assign inten = intensity_eff[c*PIXEL_WIDTH +: PIXEL_WIDTH];
`ifdef SPIKE_ENCODER_DET_EN
        logic [PIXEL_WIDTH-1:0] acc, acc_base;
        logic [PIXEL_WIDTH:0]   sum;
        assign acc_base     = start_fire ? '0 : acc;
        assign sum          = {1'b0, acc_base} + {1'b0, inten};
        assign spike_raw[c] = sum[PIXEL_WIDTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc <= '0;
            end else if (start_fire || step_fire) begin
                acc <= sum[PIXEL_WIDTH-1:0];
            end
        end
`else
        localparam logic [15:0] LFSR_MASK = 16'hB400;
        localparam logic [15:0] SEED_RAW  = LFSR_SEED ^ 16'(c * 16'h1111);
        localparam logic [15:0] SEED      = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;
        logic [15:0] lfsr, cur;
        // Reseed on start so identical data always yields an identical train.
        assign cur          = start_fire ? SEED : lfsr;
        assign spike_raw[c] = cur[PIXEL_WIDTH-1:0] < inten;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lfsr <= SEED;
            end else if (start_fire || step_fire) begin
                lfsr <= {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
            end
        end
`endif
    end

    // Next-state and registered-output values.
    always_comb begin
        state_nxt      = state;
        ts_nxt         = '0;
        spike_nxt      = '0;
        step_valid_nxt = 1'b0;
        done_nxt       = 1'b0;
        if (clear) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt      = S_RUN;
                        spike_nxt      = spike_raw;
                        step_valid_nxt = 1'b1;
                    end
                end
                S_RUN: begin
                    if (timestep == LAST_TS) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        ts_nxt         = timestep + TS_W'(1);
                        spike_nxt      = spike_raw;
                        step_valid_nxt = 1'b1;
                    end
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
        load_ready_nxt = (state_nxt == S_IDLE);
        busy_nxt       = (state_nxt == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            intensity  <= '0;
            timestep   <= '0;
            spike_out  <= '0;
            step_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_nxt;
            intensity  <= intensity_eff;
            timestep   <= ts_nxt;
            spike_out  <= spike_nxt;
            step_valid <= step_valid_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            load_ready <= load_ready_nxt;
        end
    end

endmodule

// File: tb/tb_spike_encoder.sv
// Directed self-checking bench for spike_encoder (default parameters, either build mode).
module tb_spike_encoder;

    localparam int NC = 4;
    localparam int PW = 8;
    localparam int NT = 16;

    typedef logic [NT-1:0][NC-1:0] train_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic          load_ready;
    logic [NC*PW-1:0] load_data;
    logic          start;
    logic          clear;
    logic          busy;
    logic          done;
    logic          step_valid;
    logic [3:0]    timestep;
    logic [NC-1:0] spike_out;

    int tests = 0;
    int fails = 0;

    spike_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .start      (start),
        .clear      (clear),
        .busy       (busy),
        .done       (done),
        .step_valid (step_valid),
        .timestep   (timestep),
        .spike_out  (spike_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_spike(input int c, input int t, input logic [7:0] inten);
`ifdef SPIKE_ENCODER_DET_EN
        int before, after;
        before = (t * int'(inten)) / 256;
        after  = ((t + 1) * int'(inten)) / 256;
        return after > before;
`else
        logic [15:0] l;
        l = 16'hACE1 ^ 16'(c * 16'h1111);
        if (l == 16'h0000) l = 16'h0001;
        for (int k = 0; k < t; k++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        return l[7:0] < inten;
`endif
    endfunction

    function automatic logic [NC-1:0] exp_vec(input logic [NC*PW-1:0] data, input int t);
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = exp_spike(c, t, data[c*PW +: PW]);
        return v;
    endfunction

    function automatic logic [NT-1:0] ch_bits(input train_t tr, input int c);
        logic [NT-1:0] b;
        for (int t = 0; t < NT; t++) b[t] = tr[t][c];
        return b;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " load_ready"}, 32'(load_ready), 32'd1);
        check({tag, " busy"},       32'(busy),       32'd0);
        check({tag, " done"},       32'(done),       32'd0);
        check({tag, " step_valid"}, 32'(step_valid), 32'd0);
        check({tag, " spike_out"},  32'(spike_out),  32'd0);
        check({tag, " timestep"},   32'(timestep),   32'd0);
    endtask

    // Expects timestep 0 on the outputs; walks the window, then checks the done pulse.
    task automatic run_check(input string tag, input logic [NC*PW-1:0] data, input bit poke,
                             output train_t tr);
        int busy_cnt;
        busy_cnt = 0;
        for (int t = 0; t < NT; t++) begin
            check($sformatf("%s step_valid t=%0d", tag, t), 32'(step_valid), 32'd1);
            check($sformatf("%s timestep t=%0d", tag, t),   32'(timestep),   32'(t));
            check($sformatf("%s load_ready t=%0d", tag, t), 32'(load_ready), 32'd0);
            check($sformatf("%s spike t=%0d", tag, t),      32'(spike_out),  32'(exp_vec(data, t)));
            tr[t] = spike_out;
            if (busy) busy_cnt++;
            if (poke && t == 3) begin
                load_valid = 1'b1;
                load_data  = ~data;
                start      = 1'b1;
            end
            if (poke && t == 4) begin
                load_valid = 1'b0;
                load_data  = data;
                start      = 1'b0;
            end
            tick();
        end
        if (busy) busy_cnt++;
        check({tag, " done pulse"},      32'(done),       32'd1);
        check({tag, " done step_valid"}, 32'(step_valid), 32'd0);
        check({tag, " done spike"},      32'(spike_out),  32'd0);
        check({tag, " done load_ready"}, 32'(load_ready), 32'd0);
        check({tag, " busy cycles"},     32'(busy_cnt),   32'(NT));
        tick();
        check({tag, " done cleared"},    32'(done),       32'd0);
        check({tag, " ready again"},     32'(load_ready), 32'd1);
    endtask

    logic [NC*PW-1:0] data_a, data_b;
    train_t tr_a, tr_b, tr_c, tr_d, tr_e, tr_z, tr_f;

    initial begin
        rst        = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        start      = 1'b0;
        clear      = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_idle("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Load and start together: the run must use the new data.
        data_a     = {8'd64, 8'd255, 8'd128, 8'd0};
        load_valid = 1'b1;
        load_data  = data_a;
        start      = 1'b1;
        tick();
        load_valid = 1'b0;
        start      = 1'b0;
        run_check("fwd", data_a, 1'b0, tr_a);
        check("fwd ch0 zero never spikes", 32'(ch_bits(tr_a, 0)), 32'h0000);
`ifdef SPIKE_ENCODER_DET_EN
        check("fwd ch3 I=64 pattern", 32'(ch_bits(tr_a, 3)), 32'h8888);
        check("fwd ch2 I=255 pattern", 32'(ch_bits(tr_a, 2)), 32'hFFFE);
`endif

        // Handshake: load/start during RUN are ignored.
        data_b     = {8'd1, 8'd200, 8'd17, 8'd128};
        load_valid = 1'b1;
        load_data  = data_b;
        start      = 1'b1;
        tick();
        load_valid = 1'b0;
        start      = 1'b0;
        run_check("hs", data_b, 1'b1, tr_b);
`ifdef SPIKE_ENCODER_DET_EN
        check("hs ch0 I=128 first 8", 32'(ch_bits(tr_b, 0) & 16'h00FF), 32'h00AA);
`else
        check("hs ch0 I=128 first 8", 32'(ch_bits(tr_b, 0) & 16'h00FF), 32'h0076);
`endif

        // Repeatability: back-to-back runs on the retained intensities.
        start = 1'b1;
        tick();
        start = 1'b0;
        run_check("rep1", data_b, 1'b0, tr_c);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_check("rep2", data_b, 1'b0, tr_d);
        check("rep trains equal", 32'(tr_c ^ tr_d), 32'd0);
        check("rep vs hs train", 32'(tr_c ^ tr_b), 32'd0);

        // Abort at timestep 7 with start held high.
        start = 1'b1;
        tick();
        for (int t = 0; t < 7; t++) begin
            check($sformatf("abort ts t=%0d", t), 32'(timestep), 32'(t));
            tick();
        end
        check("abort ts at 7", 32'(timestep), 32'd7);
        clear = 1'b1;
        tick();
        check_idle("abort");
        clear = 1'b0;
        tick();
        start = 1'b0;
        run_check("restart", data_b, 1'b0, tr_e);
        check("restart train", 32'(tr_e ^ tr_b), 32'd0);

        // Asynchronous reset mid-run at timestep 5.
        load_valid = 1'b1;
        load_data  = data_a;
        start      = 1'b1;
        tick();
        load_valid = 1'b0;
        start      = 1'b0;
        for (int t = 0; t < 5; t++) tick();
        check("rst_mid ts at 5", 32'(timestep), 32'd5);
        rst = 1'b1;
        #1;
        check_idle("rst_mid");
        #1 rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_check("zero", '0, 1'b0, tr_z);
        load_valid = 1'b1;
        load_data  = data_a;
        start      = 1'b1;
        tick();
        load_valid = 1'b0;
        start      = 1'b0;
        run_check("fresh", data_a, 1'b0, tr_f);
        check("fresh vs first train", 32'(tr_f ^ tr_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spike_encoder.md
Name: spike_encoder

Overview:
- Rate-coded input encoder for the SNN fabric. It converts a vector of pixel intensities into per-channel spike trains over a fixed window of timesteps.
- Its spike_out vector drives the spike_in bus of a layer of integrate-and-fire neurons, one bit per input channel.
- Spike probability per timestep is proportional to intensity. The random source is one LFSR per channel.

Parameters:
- NUM_CHANNELS, 4, number of input channels (width of spike_out)
- PIXEL_WIDTH, 8, bits per intensity value
- NUM_TIMESTEPS, 16, timesteps per encoding window (>=2)
- LFSR_SEED, 16'hACE1, base seed for the per-channel LFSRs

Ports:
- clk  input  1  clock
- rst  input  1  reset
- load_valid  input  1  intensity vector valid
- load_ready  output  1  encoder can accept intensities (high in IDLE only)
- load_data  input  NUM_CHANNELS*PIXEL_WIDTH  intensities; channel c is at bits [c*PIXEL_WIDTH +: PIXEL_WIDTH]
- start  input  1  begin an encoding window
- clear  input  1  synchronous abort
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after the final timestep
- step_valid  output  1  spike_out holds a valid timestep
- timestep  output  $clog2(NUM_TIMESTEPS)  index of the timestep on spike_out
- spike_out  output  NUM_CHANNELS  spikes for the current timestep

Behaviour:
- Reset is asynchronous, active-high (rst); clock is clk.
- Reset values:
  - state=IDLE
  - all outputs 0 except load_ready=1
  - intensity registers 0
  - LFSRs at their seeds
- States and transitions:
  - IDLE -> RUN when start=1.
  - RUN -> DONE after timestep NUM_TIMESTEPS-1 is issued.
  - DONE -> IDLE unconditionally after one cycle.
  - clear=1 in any state -> IDLE next cycle. spike_out, step_valid, busy and done go to 0. clear has priority over start.
- Load:
  - load_valid && load_ready captures load_data into the intensity registers.
  - A load in the same cycle as start is captured, and the run uses the NEW data (forwarded).
  - load_valid outside IDLE is ignored; load_ready=0 there.
- start:
  - Ignored outside IDLE.
  - On acceptance, each channel LFSR is reseeded and timestep is cleared. Runs with identical data give identical spike trains.
- Seeds:
  - Channel c seed = LFSR_SEED ^ (c*16'h1111).
  - If the seed is zero, use 16'h0001.
- LFSR: 16-bit Galois, mask 16'hB400. next = (l>>1) ^ (l[0] ? 16'hB400 : 0).
- Per RUN cycle (all outputs registered):
  - rand = l[PIXEL_WIDTH-1:0] of the current LFSR value.
  - spike_out[c] = (rand < intensity[c]).
  - The LFSR then advances.
- Latency: spike_out for timestep 0 is valid the cycle after start is accepted. The NUM_TIMESTEPS consecutive cycles carry step_valid=1 with timestep=0..NUM_TIMESTEPS-1.
- Boundaries:
  - Intensity 0 never spikes.
  - Intensity 2^PIXEL_WIDTH-1 spikes on every timestep except when rand is all ones.
- done:
  - Asserted for exactly one cycle, in the cycle after the last step_valid.
  - spike_out=0 in DONE.
  - load_ready returns to 1 in the following IDLE cycle.
- Width rule: the comparison is unsigned on PIXEL_WIDTH bits. PIXEL_WIDTH must be <=16.

Optional Feature:
- Macro: SPIKE_ENCODER_DET_EN.
- Defined: the LFSR compare is replaced by a per-channel phase accumulator.
  - acc is PIXEL_WIDTH bits and is cleared on start.
  - Each timestep: sum = acc + intensity (PIXEL_WIDTH+1 bits); spike_out[c] = sum[PIXEL_WIDTH]; acc = sum[PIXEL_WIDTH-1:0].
  - Spike count per window = floor(NUM_TIMESTEPS*I / 2^PIXEL_WIDTH).
  - The LFSR logic is not instantiated.
- Undefined: LFSR mode as described in Behaviour.
- Handshake and timing are identical in both modes.

Test Plan:
- Reset mid-RUN:
  - Stimulus: load [0,128,255,64]; start; assert rst at timestep 5.
  - Response: all outputs 0 and load_ready=1 immediately; intensity registers 0. After rst is released, a new start produces the same train as a fresh run.
- LFSR mode, channel 0 and one-bit-per-channel PIXEL_WIDTH:
  - Stimulus: NUM_CHANNELS=1, load intensity 0.
  - Response: spike_out stays 0 for all 16 steps; done pulses exactly once, one cycle after timestep 15.
  - Stimulus: PIXEL_WIDTH=1, intensities [0,1,1,1].
  - Response: channel 0 never spikes. Channels 1-3 spike exactly on steps where LFSR bit0=0. Seeds are ACE1, BDF0, 8EC3, 9FD2; the first step is decided by bit0 of each seed.
- Deterministic mode:
  - Stimulus: SPIKE_ENCODER_DET_EN, intensities [0,64,128,255].
  - Response over 16 steps:
    - ch0: 0 spikes.
    - ch1: 4 spikes at t=3,7,11,15.
    - ch2: 8 spikes at odd t.
    - ch3: 15 spikes, all steps except t=0.
- Handshake edge cases:
  - Stimulus: load_valid and start in the same IDLE cycle with [128,...].
  - Response: the run uses 128; load_valid during RUN is ignored (load_ready=0); start during RUN is ignored.
- Repeatability:
  - Stimulus: two back-to-back LFSR runs with the same data.
  - Response: identical spike_out sequences; timestep runs 0..15 each run; busy is high for exactly 16 cycles.
- Abort:
  - Stimulus: clear at timestep 7, with start held high.
  - Response: IDLE next cycle, spike_out=0, no done pulse; the next start restarts at timestep 0.
